// File: rtl/apg_pattern_loader.sv
// apg_pattern_loader
//   Feeds the APG sample buffer. Takes run-length-encoded commands
//   {repeat, sample} on a valid/ready stream and expands each one into
//   repeat+1 consecutive sample writes, one write_channel_wrStrobe per word.
//   Writes are held off whenever the reported buffer occupancy plus the
//   strobes not yet visible in that occupancy would reach NUM_SAMP.
//
// Ports
//   axi_clk, axi_resetn      clock, synchronous active-low reset
//   cmd_valid/ready/data/last command stream, data = {repeat, sample}
//   clear                    synchronous abort/restart
//   write_buffer_len         current APG buffer occupancy
//   write_channel            sample presented to the APG
//   write_channel_wrStrobe   one pulse per sample written
//   busy, stalled, done      status (done pulses after a cmd_last command)
//   words_written            strobes since reset/clear, wraps at 2^32
//   checksum                 running 16-bit sample sum
//
// Configuration
//   APG_LOADER_CHECKSUM_EN   when defined, checksum accumulates the
//                            zero-extended sample of every strobe; when
//                            undefined, checksum is tied to zero.
//
//   state  | meaning
//   IDLE   | no command in progress, ready for a new one
//   EXPAND | emitting words of the current command

module apg_pattern_loader #(
  parameter int NUM_SIG  = 14,
  parameter int NUM_SAMP = 128,
  parameter int CNT_W    = 16,
  parameter int LEN_LAT  = 2
) (
  input  logic                     axi_clk,
  input  logic                     axi_resetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CNT_W+NUM_SIG-1:0] cmd_data,
  input  logic                     cmd_last,
  input  logic                     clear,
  input  logic [31:0]              write_buffer_len,
  output logic [NUM_SIG-1:0]       write_channel,
  output logic                     write_channel_wrStrobe,
  output logic                     busy,
  output logic                     stalled,
  output logic                     done,
  output logic [31:0]              words_written,
  output logic [15:0]              checksum
);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  localparam logic [CNT_W:0] REM_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_t             state;
  logic [NUM_SIG-1:0] sample;
  logic [NUM_SIG-1:0] last_sample;
  logic [CNT_W:0]     remaining;
  logic               last_flag;
  logic [LEN_LAT-1:0] hist;
  logic [LEN_LAT:0]   hist_shift;
  logic               done_q;
  logic [31:0]        words_q;

  logic [32:0]        inflight;
  logic [32:0]        occupancy;
  logic               strobe_ok;
  logic               strobe;
  logic               accept;
  logic               final_word;

  logic [CNT_W-1:0]   cmd_repeat;
  logic [NUM_SIG-1:0] cmd_sample;

  assign cmd_repeat = cmd_data[CNT_W+NUM_SIG-1:NUM_SIG];
  assign cmd_sample = cmd_data[NUM_SIG-1:0];

  // Strobes from the last LEN_LAT cycles are not yet counted in
  // write_buffer_len, so they are added back before the compare.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LEN_LAT; i++) begin
      inflight = inflight + {32'd0, hist[i]};
    end
  end

  assign occupancy = {1'b0, write_buffer_len} + inflight;
  assign strobe_ok = occupancy < 33'(NUM_SAMP);

  // The strobe has to react to occupancy in the same cycle it is issued,
  // otherwise the inflight window would be one cycle short.
  assign strobe     = (state == EXPAND) && strobe_ok && !clear;
  assign final_word = strobe && (remaining == REM_ONE);

  // The EXPAND term lets the next command load on the final word of the
  // current one, so chained commands stream without a bubble.
  assign cmd_ready = axi_resetn && !clear &&
                     ((state == IDLE) ||
                      ((state == EXPAND) && (remaining == REM_ONE) &&
                       strobe_ok && !last_flag));
  assign accept    = cmd_valid && cmd_ready;

  assign hist_shift = {hist, strobe};

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      state       <= IDLE;
      sample      <= '0;
      last_sample <= '0;
      remaining   <= '0;
      last_flag   <= 1'b0;
      hist        <= '0;
      done_q      <= 1'b0;
      words_q     <= '0;
    end else if (clear) begin
      state     <= IDLE;
      remaining <= '0;
      last_flag <= 1'b0;
      hist      <= '0;
      done_q    <= 1'b0;
      words_q   <= '0;
    end else begin
      hist   <= hist_shift[LEN_LAT-1:0];
      done_q <= 1'b0;

      if (strobe) begin
        words_q     <= words_q + 32'd1;
        last_sample <= sample;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state     <= EXPAND;
            sample    <= cmd_sample;
            remaining <= {1'b0, cmd_repeat} + REM_ONE;
            last_flag <= cmd_last;
          end
        end
        EXPAND: begin
          if (final_word) begin
            if (last_flag) begin
              state     <= IDLE;
              remaining <= '0;
              last_flag <= 1'b0;
              done_q    <= 1'b1;
            end else if (accept) begin
              sample    <= cmd_sample;
              remaining <= {1'b0, cmd_repeat} + REM_ONE;
              last_flag <= cmd_last;
            end else begin
              state     <= IDLE;
              remaining <= '0;
            end
          end else if (strobe) begin
            remaining <= remaining - REM_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Between strobes the channel keeps showing the last sample written,
  // not the sample of a command that is still waiting to go out.
  assign write_channel          = strobe ? sample : last_sample;
  assign write_channel_wrStrobe = strobe;
  assign busy                   = (state != IDLE);
  assign stalled                = (state == EXPAND) && !strobe_ok;
  assign done                   = done_q;
  assign words_written          = words_q;

`ifdef APG_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;
  logic [31:0] sample_ext;

  assign sample_ext = 32'(sample);

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn || clear) begin
      checksum_q <= '0;
    end else if (strobe) begin
      checksum_q <= checksum_q + sample_ext[15:0];
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_apg_pattern_loader.sv
// Directed bench for apg_pattern_loader: a cycle table for single commands,
// chaining, occupancy stalls and clear, then hand-written sequences for the
// buffer-fill stall, reset mid-expansion and the checksum.

module tb_apg_pattern_loader;

  localparam int NUM_SIG  = 14;
  localparam int NUM_SAMP = 128;
  localparam int CNT_W    = 16;
  localparam int LEN_LAT  = 2;

  logic                     axi_clk;
  logic                     axi_resetn;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [CNT_W+NUM_SIG-1:0] cmd_data;
  logic                     cmd_last;
  logic                     clear;
  logic [31:0]              write_buffer_len;
  logic [NUM_SIG-1:0]       write_channel;
  logic                     write_channel_wrStrobe;
  logic                     busy;
  logic                     stalled;
  logic                     done;
  logic [31:0]              words_written;
  logic [15:0]              checksum;

  int n_checks = 0;
  int n_fail   = 0;

  apg_pattern_loader #(
    .NUM_SIG (NUM_SIG),
    .NUM_SAMP(NUM_SAMP),
    .CNT_W   (CNT_W),
    .LEN_LAT (LEN_LAT)
  ) dut (
    .axi_clk               (axi_clk),
    .axi_resetn            (axi_resetn),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_data              (cmd_data),
    .cmd_last              (cmd_last),
    .clear                 (clear),
    .write_buffer_len      (write_buffer_len),
    .write_channel         (write_channel),
    .write_channel_wrStrobe(write_channel_wrStrobe),
    .busy                  (busy),
    .stalled               (stalled),
    .done                  (done),
    .words_written         (words_written),
    .checksum              (checksum)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic        valid;
    logic [15:0] rep;
    logic [13:0] samp;
    logic        last;
    logic        clr;
    logic [31:0] len;
    logic        e_ready;
    logic        e_strobe;
    logic [13:0] e_wc;
    logic        e_busy;
    logic        e_stalled;
    logic        e_done;
    logic [31:0] e_ww;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic valid, logic [15:0] rep, logic [13:0] samp,
                              logic last, logic clr, logic [31:0] len,
                              logic e_ready, logic e_strobe, logic [13:0] e_wc,
                              logic e_busy, logic e_stalled, logic e_done,
                              logic [31:0] e_ww);
    vec_t v;
    v.valid = valid; v.rep = rep; v.samp = samp; v.last = last;
    v.clr = clr; v.len = len;
    v.e_ready = e_ready; v.e_strobe = e_strobe; v.e_wc = e_wc;
    v.e_busy = e_busy; v.e_stalled = e_stalled; v.e_done = e_done;
    v.e_ww = e_ww;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_clk);
    #1;
  endtask

  // Drives a command and holds it until accepted. Returns just after the
  // accepting edge with cmd_valid still asserted.
  task automatic send_cmd(input logic [15:0] rep, input logic [13:0] samp, input logic last);
    bit got;
    got = 0;
    cmd_valid = 1'b1;
    cmd_data  = {rep, samp};
    cmd_last  = last;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge axi_clk);
      if (cmd_ready) got = 1;
      step();
    end
    if (!got) chk("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge axi_clk);
      if (done) seen = 1;
      else step();
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    axi_resetn       = 1'b0;
    cmd_valid        = 1'b0;
    cmd_data         = '0;
    cmd_last         = 1'b0;
    clear            = 1'b0;
    write_buffer_len = '0;

    //        valid rep samp  last clr len            rdy stb wc     busy stl done ww
    vecs[0]  = mk(1, 3, 'h1A5, 1, 0, 0,             1, 0, 'h000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 'h000, 0, 0, 0,             0, 1, 'h1A5, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 'h000, 0, 0, 0,             0, 1, 'h1A5, 1, 0, 0, 1);
    vecs[3]  = mk(0, 0, 'h000, 0, 0, 0,             0, 1, 'h1A5, 1, 0, 0, 2);
    vecs[4]  = mk(0, 0, 'h000, 0, 0, 0,             0, 1, 'h1A5, 1, 0, 0, 3);
    vecs[5]  = mk(0, 0, 'h000, 0, 0, 0,             1, 0, 'h1A5, 0, 0, 1, 4);
    vecs[6]  = mk(1, 0, 'h001, 0, 0, 0,             1, 0, 'h1A5, 0, 0, 0, 4);
    vecs[7]  = mk(1, 0, 'h002, 1, 0, 0,             1, 1, 'h001, 1, 0, 0, 4);
    vecs[8]  = mk(0, 0, 'h000, 0, 0, 0,             0, 1, 'h002, 1, 0, 0, 5);
    vecs[9]  = mk(0, 0, 'h000, 0, 0, 0,             1, 0, 'h002, 0, 0, 1, 6);
    vecs[10] = mk(1, 1, 'h0AA, 1, 0, 0,             1, 0, 'h002, 0, 0, 0, 6);
    vecs[11] = mk(0, 0, 'h000, 0, 0, 32'hFFFF_FFFF, 0, 0, 'h002, 1, 1, 0, 6);
    vecs[12] = mk(0, 0, 'h000, 0, 0, 128,           0, 0, 'h002, 1, 1, 0, 6);
    vecs[13] = mk(0, 0, 'h000, 0, 0, 127,           0, 1, 'h0AA, 1, 0, 0, 6);
    vecs[14] = mk(0, 0, 'h000, 0, 0, 127,           0, 0, 'h0AA, 1, 1, 0, 7);
    vecs[15] = mk(0, 0, 'h000, 0, 0, 126,           0, 1, 'h0AA, 1, 0, 0, 7);
    vecs[16] = mk(0, 0, 'h000, 0, 0, 0,             1, 0, 'h0AA, 0, 0, 1, 8);
    vecs[17] = mk(1, 9, 'h155, 1, 0, 0,             1, 0, 'h0AA, 0, 0, 0, 8);
    vecs[18] = mk(0, 0, 'h000, 0, 0, 0,             0, 1, 'h155, 1, 0, 0, 8);
    vecs[19] = mk(0, 0, 'h000, 0, 0, 0,             0, 1, 'h155, 1, 0, 0, 9);
    vecs[20] = mk(0, 0, 'h000, 0, 0, 0,             0, 1, 'h155, 1, 0, 0, 10);
    vecs[21] = mk(1, 0, 'h3FF, 0, 1, 0,             0, 0, 'h155, 1, 0, 0, 11);
    vecs[22] = mk(0, 0, 'h000, 0, 0, 0,             1, 0, 'h155, 0, 0, 0, 0);
    vecs[23] = mk(0, 0, 'h000, 0, 0, 0,             1, 0, 'h155, 0, 0, 0, 0);

    // Reset state, observed while reset is still asserted.
    repeat (2) step();
    @(negedge axi_clk);
    chk("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst strobe", {31'd0, write_channel_wrStrobe}, 32'd0);
    chk("rst write_channel", 32'(write_channel), 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst stalled", {31'd0, stalled}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst words_written", words_written, 32'd0);
    chk("rst checksum", 32'(checksum), 32'd0);
    step();
    axi_resetn = 1'b1;

    for (int i = 0; i < 24; i++) begin
      cmd_valid        = vecs[i].valid;
      cmd_data         = {vecs[i].rep, vecs[i].samp};
      cmd_last         = vecs[i].last;
      clear            = vecs[i].clr;
      write_buffer_len = vecs[i].len;
      @(negedge axi_clk);
      chk($sformatf("vec%0d cmd_ready", i), {31'd0, cmd_ready}, {31'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d strobe", i), {31'd0, write_channel_wrStrobe}, {31'd0, vecs[i].e_strobe});
      chk($sformatf("vec%0d write_channel", i), 32'(write_channel), 32'(vecs[i].e_wc));
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      chk($sformatf("vec%0d stalled", i), {31'd0, stalled}, {31'd0, vecs[i].e_stalled});
      chk($sformatf("vec%0d done", i), {31'd0, done}, {31'd0, vecs[i].e_done});
      chk($sformatf("vec%0d words_written", i), words_written, vecs[i].e_ww);
      step();
    end
    cmd_valid = 1'b0;
    clear     = 1'b0;

    // Buffer nearly full: one word fits, then the buffer reports full and
    // the loader must hold until occupancy drops.
    write_buffer_len = 127;
    send_cmd(16'd4, 14'h2BC, 1'b1);
    cmd_valid = 1'b0;
    @(negedge axi_clk);
    chk("fill first strobe", {31'd0, write_channel_wrStrobe}, 32'd1);
    chk("fill first wc", 32'(write_channel), 32'h2BC);
    step();
    write_buffer_len = 128;
    for (int i = 0; i < 12; i++) begin
      @(negedge axi_clk);
      chk($sformatf("fill stall%0d stalled", i), {31'd0, stalled}, 32'd1);
      chk($sformatf("fill stall%0d strobe", i), {31'd0, write_channel_wrStrobe}, 32'd0);
      step();
    end
    write_buffer_len = 100;
    for (int i = 0; i < 4; i++) begin
      @(negedge axi_clk);
      chk($sformatf("fill resume%0d strobe", i), {31'd0, write_channel_wrStrobe}, 32'd1);
      step();
    end
    @(negedge axi_clk);
    chk("fill done", {31'd0, done}, 32'd1);
    chk("fill words_written", words_written, 32'd5);
    step();
    write_buffer_len = 0;

    // Reset in the middle of an expansion.
    send_cmd(16'd9, 14'h0F0, 1'b1);
    cmd_valid = 1'b0;
    step();
    axi_resetn = 1'b0;
    step();
    @(negedge axi_clk);
    chk("midrst strobe", {31'd0, write_channel_wrStrobe}, 32'd0);
    chk("midrst write_channel", 32'(write_channel), 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst words_written", words_written, 32'd0);
    chk("midrst cmd_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    axi_resetn = 1'b1;
    send_cmd(16'd3, 14'h1A5, 1'b1);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge axi_clk);
      chk($sformatf("postrst strobe%0d", i), {31'd0, write_channel_wrStrobe}, 32'd1);
      step();
    end
    @(negedge axi_clk);
    chk("postrst done", {31'd0, done}, 32'd1);
    chk("postrst busy", {31'd0, busy}, 32'd0);
    chk("postrst words_written", words_written, 32'd4);
    step();

    // Checksum over a fresh pattern after clear.
    clear = 1'b1;
    step();
    clear = 1'b0;
    send_cmd(16'd1, 14'h0001, 1'b0);
    send_cmd(16'd0, 14'h0003, 1'b1);
    cmd_valid = 1'b0;
    wait_done("cksum done");
    step();
    @(negedge axi_clk);
    chk("cksum words_written", words_written, 32'd3);
`ifdef APG_LOADER_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'h0005);
`else
    chk("checksum", 32'(checksum), 32'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
